apb_cmd_master: RTL
===================

Name: apb_cmd_master

Overview:
- Upstream APB requester. Drives the APB completer memory on the same bus.
- Accepts one command at a time on a valid/ready command port and runs a standard APB4 SETUP/ACCESS transfer for it.
- Returns read data, or a timeout error, on a valid/ready response port.
- Single clock domain (b_pclk). Sits between the bridge's command-side logic and the APB slave.

Parameters:
- ADDR_WD, 32, APB address width.
- DATA_WD, 32, APB data width.
- STRB_WD, 4, write strobe width (DATA_WD/8).
- PROT_WD, 3, pprot width.
- TIMEOUT, 16, maximum ACCESS cycles allowed with b_pready low before the transfer is aborted. 0 disables the timeout.

Ports:
- b_pclk  input  1  clock; all logic on the rising edge.
- b_prst  input  1  reset, synchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when high together with cmd_valid.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  ADDR_WD  transfer address.
- cmd_wdata  input  DATA_WD  write data.
- cmd_strb  input  STRB_WD  write byte strobes.
- cmd_prot  input  PROT_WD  protection attributes.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed when high together with rsp_valid.
- rsp_rdata  output  DATA_WD  read data; 0 for writes and errors.
- rsp_err  output  1  1 = transfer timed out.
- b_psel  output  1  APB select.
- b_penable  output  1  APB enable.
- b_pwrite  output  1  APB direction.
- b_paddr  output  ADDR_WD  APB address.
- b_pwdata  output  DATA_WD  APB write data.
- b_pprot  output  PROT_WD  APB protection.
- b_pstrb  output  STRB_WD  APB strobes.
- b_prdata  input  DATA_WD  APB read data.
- b_pready  input  1  APB ready.

Behaviour:
- Reset (b_prst=1 at an edge): state=IDLE. These outputs go to 0: b_psel, b_penable, b_pwrite, b_paddr, b_pwdata, b_pprot, b_pstrb, rsp_valid, rsp_err, rsp_rdata, and the timeout counter. All outputs are registered except cmd_ready.
- Reset mid-operation: an in-flight transfer is abandoned and a pending response is discarded. The bus is idle from the next cycle.
- cmd_ready = (state==IDLE) && !rsp_valid. It is combinational, and it is 0 during reset.
- FSM states:
  - IDLE: on cmd_valid && cmd_ready, register the command onto the b_* outputs. b_psel=1, b_penable=0 next cycle. Go to SETUP.
  - SETUP: one cycle exactly. Next cycle b_penable=1. Go to ACCESS. Counter cleared.
  - ACCESS, b_pready=1: complete. Next cycle b_psel=0, b_penable=0, rsp_valid=1, rsp_err=0. rsp_rdata = b_prdata sampled this edge for reads, 0 for writes. Go to IDLE.
  - ACCESS, b_pready=0, TIMEOUT!=0, counter==TIMEOUT-1: abort. Next cycle b_psel=0, b_penable=0, rsp_valid=1, rsp_err=1, rsp_rdata=0. Go to IDLE.
  - ACCESS, other cases: stay in ACCESS and increment the counter. The counter saturates and never wraps.
- Bus stability: b_paddr, b_pwrite, b_pwdata, b_pprot and b_pstrb are stable from SETUP through the last ACCESS cycle. They hold their last values in IDLE and change only on command acceptance.
- Reads drive b_pstrb=0 and b_pwdata=0. Writes pass cmd_strb through unchanged. b_paddr passes cmd_addr through unmodified; no alignment forcing.
- Latency: command accepted at edge N gives SETUP in cycle N+1 and ACCESS in cycle N+2. With b_pready=1, rsp_valid is high in cycle N+3. Each wait state adds 1 cycle.
- Response hold: rsp_valid, rsp_rdata and rsp_err hold until rsp_valid && rsp_ready. rsp_valid clears on the next edge. No new command is accepted while rsp_valid=1.
- Back-to-back commands: the minimum issue interval is 4 cycles, with rsp_ready tied high.

Test Plan:
- Write with b_pready tied 1: cmd write addr=0x10, wdata=0xDEADBEEF, strb=0xF, prot=0, accepted at edge N. Required: psel=1/penable=0 in N+1; psel=1/penable=1 in N+2; bus idle and rsp_valid=1, rsp_err=0, rsp_rdata=0 in N+3.
- Read-back: read addr=0x10 with b_prdata=0xDEADBEEF in the completing ACCESS cycle. Required: rsp_rdata=0xDEADBEEF, rsp_err=0, b_pstrb=0, b_pwrite=0 throughout.
- Wait states: b_pready low for 3 ACCESS cycles, then high. Required: ACCESS lasts 4 cycles, address/data stable throughout, rsp_valid in N+6.
- Timeout: TIMEOUT=4, b_pready held 0. Required: abort after the 4th ACCESS cycle, rsp_valid=1, rsp_err=1, rsp_rdata=0, psel drops the same cycle rsp_valid rises.
- Backpressure: rsp_ready=0 for 5 cycles with cmd_valid held high. Required: rsp_* stable, cmd_ready=0 throughout; next command accepted the cycle after the rsp handshake.
- Reset mid-ACCESS: assert b_prst in an ACCESS wait cycle. Required: after that edge all outputs are 0, no response is produced, and cmd_ready=1 once reset deasserts.

Source files
------------

// File: rtl/apb_cmd_master.sv
// ---------------------------------------------------------------------------
// apb_cmd_master
//
// APB4 requester. Takes one command at a time from a valid/ready command
// port, runs a SETUP/ACCESS transfer on the APB bus for it, and returns the
// outcome (read data or timeout error) on a valid/ready response port.
//
// Ports
//   b_pclk, b_prst        clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (cmd_ready is combinational)
//   cmd_write/addr/wdata/strb/prot   command payload
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_err    response payload (rdata is 0 for writes/errors)
//   b_psel ... b_pstrb    APB request outputs (all registered)
//   b_prdata, b_pready    APB completer return
//
// TIMEOUT is the number of ACCESS cycles with b_pready low that are
// tolerated; on the last of them the transfer is aborted with rsp_err=1.
// TIMEOUT=0 waits forever.
// ---------------------------------------------------------------------------
module apb_cmd_master #(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 32,
    parameter int STRB_WD = 4,
    parameter int PROT_WD = 3,
    parameter int TIMEOUT = 16
) (
    input  logic               b_pclk,
    input  logic               b_prst,
    // command port
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_WD-1:0] cmd_addr,
    input  logic [DATA_WD-1:0] cmd_wdata,
    input  logic [STRB_WD-1:0] cmd_strb,
    input  logic [PROT_WD-1:0] cmd_prot,
    // response port
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_WD-1:0] rsp_rdata,
    output logic               rsp_err,
    // APB requester side
    output logic               b_psel,
    output logic               b_penable,
    output logic               b_pwrite,
    output logic [ADDR_WD-1:0] b_paddr,
    output logic [DATA_WD-1:0] b_pwdata,
    output logic [PROT_WD-1:0] b_pprot,
    output logic [STRB_WD-1:0] b_pstrb,
    input  logic [DATA_WD-1:0] b_prdata,
    input  logic               b_pready
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Counter only has to reach TIMEOUT-1; one bit minimum keeps the
    // disabled / TIMEOUT=1 cases legal.
    localparam int CNT_WD = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t             state_q;
    logic [CNT_WD-1:0]  cnt_q;
    logic [CNT_WD-1:0]  cnt_d;
    logic               timeout_hit;
    logic               cmd_fire;

    logic               psel_q;
    logic               penable_q;
    logic               pwrite_q;
    logic [ADDR_WD-1:0] paddr_q;
    logic [DATA_WD-1:0] pwdata_q;
    logic [PROT_WD-1:0] pprot_q;
    logic [STRB_WD-1:0] pstrb_q;
    logic               rsp_valid_q;
    logic [DATA_WD-1:0] rsp_rdata_q;
    logic               rsp_err_q;

    // A new command is only taken when the bus is idle and the previous
    // response has been consumed; forced low while reset is asserted.
    assign cmd_ready = !b_prst && (state_q == ST_IDLE) && !rsp_valid_q;
    assign cmd_fire  = cmd_valid && cmd_ready;

    // Saturating increment: the counter never wraps back to 0, so a
    // disabled timeout cannot alias into a spurious abort.
    assign cnt_d       = (&cnt_q) ? cnt_q : (cnt_q + 1'b1);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge b_pclk) begin
        if (b_prst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pprot_q     <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rsp_valid_q && rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                    end
                    // cmd_fire implies rsp_valid_q==0, so no conflict above.
                    if (cmd_fire) begin
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        pwrite_q  <= cmd_write;
                        paddr_q   <= cmd_addr;
                        pprot_q   <= cmd_prot;
                        // Reads never present write data or strobes.
                        pwdata_q  <= cmd_write ? cmd_wdata : '0;
                        pstrb_q   <= cmd_write ? cmd_strb  : '0;
                        state_q   <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (b_pready) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= pwrite_q ? '0 : b_prdata;
                        state_q     <= ST_IDLE;
                    end else if (timeout_hit) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        state_q     <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign b_psel    = psel_q;
    assign b_penable = penable_q;
    assign b_pwrite  = pwrite_q;
    assign b_paddr   = paddr_q;
    assign b_pwdata  = pwdata_q;
    assign b_pprot   = pprot_q;
    assign b_pstrb   = pstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
